// File: rtl/attn_pkg.sv
// attn_pkg: shared state type, default sizes and arithmetic helpers for the attention engine
package attn_pkg;
  typedef enum logic [1:0] {LOAD_Q, LOAD_K, EMIT} seq_state_t;
  localparam int N_FEAT_DEF = 4;
  localparam int N_KEYS_DEF = 4;
  localparam int DW_DEF = 8;
  function automatic int acc_w(input int dw, input int n_feat);
    return 2 * dw + $clog2(n_feat) + 1;
  endfunction
  function automatic longint sat_dw(input longint x, input int dw);
    longint hi, lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    return x > hi ? hi : x < lo ? lo : x;
  endfunction
endpackage

// File: rtl/attn_mac_unit.sv
// attn_mac_unit: signed DW x DW multiply feeding an ACC_W-wide accumulator
module attn_mac_unit #(
  parameter int DW = 8,
  parameter int ACC_W = 19
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [DW-1:0]    a,
  input  logic signed [DW-1:0]    b,
  output logic signed [ACC_W-1:0] acc,
  output logic signed [ACC_W-1:0] next_sum
);
  logic signed [2*DW-1:0] prod;
  assign prod = a * b;
  assign next_sum = acc + ACC_W'(prod);
  // accumulate one product per enabled step; clear wins over enable
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) acc <= '0;
    else if (clr) acc <= '0;
    else if (en) acc <= next_sum;
endmodule

// File: rtl/attn_score_sequencer.sv
// attn_score_sequencer: streams a query then keys through the MAC and emits one score per key; define ATTN_SAT_EN to clamp scores instead of wrapping
module attn_score_sequencer
  import attn_pkg::*;
#(
  parameter int N_FEAT = N_FEAT_DEF,
  parameter int N_KEYS = N_KEYS_DEF,
  parameter int DW = DW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [DW-1:0] s_data,
  input  logic                 s_vld,
  output logic                 s_rdy,
  output logic signed [DW-1:0] m_data,
  output logic                 m_vld,
  input  logic                 m_rdy,
  output logic                 m_last,
  output logic                 busy
);
  localparam int ACC_W = acc_w(DW, N_FEAT);
  localparam int FW = $clog2(N_FEAT);
  localparam int KW = N_KEYS > 1 ? $clog2(N_KEYS) : 1;
  seq_state_t state, state_n;
  logic signed [DW-1:0] q [N_FEAT];
  logic [FW-1:0] feat_cnt;
  logic [KW-1:0] key_cnt;
  logic signed [DW-1:0] score, score_n;
  logic signed [ACC_W-1:0] next_sum;
  logic s_xfer, m_xfer, feat_last, key_last, mac_clr, mac_en;
  assign s_rdy = state != EMIT;
  assign m_vld = state == EMIT;
  assign m_data = score;
  assign m_last = m_vld & key_last;
  assign busy = (state != LOAD_Q) | (feat_cnt != '0);
  assign s_xfer = s_vld & s_rdy;
  assign m_xfer = m_vld & m_rdy;
  assign feat_last = feat_cnt == FW'(N_FEAT - 1);
  assign key_last = key_cnt == KW'(N_KEYS - 1);
  assign mac_clr = (state == LOAD_Q & s_xfer & feat_last) | (m_xfer & ~key_last);
  assign mac_en = state == LOAD_K & s_xfer;
`ifdef ATTN_SAT_EN
  assign score_n = DW'(sat_dw(longint'(next_sum), DW));
`else
  assign score_n = DW'(next_sum);
`endif
  attn_mac_unit #(.DW(DW), .ACC_W(ACC_W)) u_mac (
    .clk(clk),
    .rst_n(rst_n),
    .clr(mac_clr),
    .en(mac_en),
    .a(q[feat_cnt]),
    .b(s_data),
    .acc(),
    .next_sum(next_sum)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= LOAD_Q;
    else state <= state_n;
  // advance on the last byte of a vector and on each score handshake
  always_comb begin
    state_n = state;
    if (state == LOAD_Q && s_xfer && feat_last) state_n = LOAD_K;
    if (state == LOAD_K && s_xfer && feat_last) state_n = EMIT;
    if (m_xfer) state_n = key_last ? LOAD_Q : LOAD_K;
  end
  // query bank, counters and the registered score
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      feat_cnt <= '0;
      key_cnt <= '0;
      score <= '0;
      for (int i = 0; i < N_FEAT; i++) q[i] <= '0;
    end else begin
      if (s_xfer) feat_cnt <= feat_last ? '0 : feat_cnt + 1'b1;
      if (s_xfer && state == LOAD_Q) q[feat_cnt] <= s_data;
      if (mac_en && feat_last) score <= score_n;
      if (m_xfer) key_cnt <= key_last ? '0 : key_cnt + 1'b1;
    end
endmodule

// File: tb/tb_attn_score_sequencer.sv
// tb_attn_score_sequencer: random and directed stimulus checked against a frame-level model of the scorer
module tb_attn_score_sequencer;
  localparam int NF = 4;
  localparam int NK = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] s_data = '0;
  logic s_vld = 1'b0, s_rdy;
  logic [7:0] m_data;
  logic m_vld, m_last, busy;
  logic m_rdy = 1'b1;
  int checks = 0, failures = 0;
  int mode = 0;
  bit gaps = 1'b0;
  typedef struct {logic [7:0] d; logic l;} exp_t;
  exp_t expq[$];
  logic [7:0] got[$];
  logic got_l[$];
  int qv[NF];
  int pos = 0, sum = 0, fi, ki;
  logic [7:0] fr [20];

  attn_score_sequencer dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_vld(s_vld), .s_rdy(s_rdy),
    .m_data(m_data), .m_vld(m_vld), .m_rdy(m_rdy), .m_last(m_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] conv(input int s);
`ifdef ATTN_SAT_EN
    return s > 127 ? 8'h7f : s < -128 ? 8'h80 : s[7:0];
`else
    return s[7:0];
`endif
  endfunction

  // frame-level model: bytes accepted, scores owed, checked every cycle
  always @(negedge clk) begin
    bit s_acc, m_acc;
    if (!rst_n) begin
      pos = 0;
      expq.delete();
    end else begin
      chk("m_vld", m_vld, expq.size() != 0);
      chk("s_rdy", s_rdy, expq.size() == 0);
      chk("busy", busy, pos != 0 || expq.size() != 0);
      if (expq.size() != 0) begin
        chk("m_data", m_data, expq[0].d);
        chk("m_last", m_last, expq[0].l);
      end
      if (m_vld && m_rdy) begin
        got.push_back(m_data);
        got_l.push_back(m_last);
      end
      s_acc = s_vld && expq.size() == 0;
      m_acc = expq.size() != 0 && m_rdy;
      if (m_acc) void'(expq.pop_front());
      if (s_acc) begin
        fi = pos % NF;
        ki = pos / NF;
        if (ki == 0) qv[fi] = $signed(s_data);
        else begin
          if (fi == 0) sum = 0;
          sum += qv[fi] * $signed(s_data);
          if (fi == NF - 1) expq.push_back('{conv(sum), ki == NK});
        end
        pos = (pos + 1) % (NF * (NK + 1));
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (mode == 1) m_rdy = 1'($urandom_range(0, 1));
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    logic took;
    s_vld = 1'b1;
    s_data = b;
    do begin
      @(negedge clk);
      took = s_rdy;
      @(posedge clk);
      #1;
      n++;
    end while (!took && n < 200);
    if (!took) chk("send_timeout", 0, 1);
    s_vld = 1'b0;
    if (gaps) repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || m_vld) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("idle_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame();
    got.delete();
    got_l.delete();
    for (int i = 0; i < 20; i++) send_byte(fr[i]);
    wait_idle();
    chk("frame_scores", got.size(), NK);
  endtask

  initial begin
    #12;
    chk("rst_m_vld", m_vld, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_s_rdy", s_rdy, 1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    // dot product 10, latency and s_rdy drop
    fr = '{1, 2, 3, 4, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    got.delete();
    got_l.delete();
    for (int i = 0; i < 8; i++) send_byte(fr[i]);
    @(negedge clk);
    chk("lat_m_vld", m_vld, 1);
    chk("lat_s_rdy", s_rdy, 0);
    @(posedge clk);
    #1;
    for (int i = 8; i < 20; i++) send_byte(fr[i]);
    wait_idle();
    if (got.size() == NK) begin
      chk("t1_score", got[0], 8'h0a);
      chk("t1_last0", got_l[0], 0);
      chk("t1_last3", got_l[3], 1);
    end else chk("t1_count", got.size(), NK);
    // positive overflow
    for (int i = 0; i < 20; i++) fr[i] = 8'd127;
    run_frame();
`ifdef ATTN_SAT_EN
    if (got.size() > 0) chk("t2_pos_ovf", got[0], 8'h7f);
`else
    if (got.size() > 0) chk("t2_pos_ovf", got[0], 8'h04);
`endif
    // negative overflow
    for (int i = 0; i < 20; i++) fr[i] = i < 4 ? 8'h80 : 8'd127;
    run_frame();
`ifdef ATTN_SAT_EN
    if (got.size() > 0) chk("t3_neg_ovf", got[0], 8'h80);
`else
    if (got.size() > 0) chk("t3_neg_ovf", got[0], 8'h00);
`endif
    // backpressure with s_vld noise
    fr = '{1, 2, 3, 4, 2, 2, 2, 2, 1, 1, 1, 1, 0, 0, 0, 0, 3, 0, 0, 0};
    m_rdy = 1'b0;
    for (int i = 0; i < 8; i++) send_byte(fr[i]);
    repeat (5) begin
      @(negedge clk);
      chk("bp_m_vld", m_vld, 1);
      chk("bp_m_data", m_data, 20);
      chk("bp_m_last", m_last, 0);
      chk("bp_s_rdy", s_rdy, 0);
      @(posedge clk);
      #1;
      s_vld = 1'($urandom_range(0, 1));
      s_data = 8'($urandom);
    end
    s_vld = 1'b0;
    m_rdy = 1'b1;
    @(negedge clk);
    chk("bp_hold", m_vld, 1);
    @(negedge clk);
    chk("bp_taken", m_vld, 0);
    @(posedge clk);
    #1;
    for (int i = 8; i < 20; i++) send_byte(fr[i]);
    wait_idle();
    // one-hot query picks the first key feature
    fr = '{1, 0, 0, 0, 1, 9, 9, 9, 2, 9, 9, 9, 3, 9, 9, 9, 4, 9, 9, 9};
    run_frame();
    if (got.size() == NK)
      for (int i = 0; i < NK; i++) begin
        chk("t5_score", got[i], i + 1);
        chk("t5_last", got_l[i], i == NK - 1);
      end
    chk("t5_idle_busy", busy, 0);
    // reset mid key vector
    fr = '{5, 5, 5, 5, 7, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 6; i++) send_byte(fr[i]);
    chk("rst_pre_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_m_vld", m_vld, 0);
    chk("arst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) fr[i] = i < 4 ? 8'd2 : i < 8 ? 8'd1 : 8'd0;
    run_frame();
    if (got.size() > 0) chk("t6_score", got[0], 8);
    // random frames with gaps and random backpressure
    gaps = 1'b1;
    mode = 1;
    repeat (30) begin
      for (int i = 0; i < 20; i++) fr[i] = 8'($urandom);
      run_frame();
    end
    mode = 0;
    gaps = 1'b0;
    #1 m_rdy = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
